// File: rtl/uno_pkg.sv
// rtl/uno_pkg.sv - shared card types, deck size and dealer state encoding
package uno_pkg;

  typedef logic [5:0] card_t;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    BLUE   = 2'd3
  } color_e;

  localparam logic [3:0] VAL_0       = 4'd0;
  localparam logic [3:0] VAL_1       = 4'd1;
  localparam logic [3:0] VAL_2       = 4'd2;
  localparam logic [3:0] VAL_3       = 4'd3;
  localparam logic [3:0] VAL_4       = 4'd4;
  localparam logic [3:0] VAL_5       = 4'd5;
  localparam logic [3:0] VAL_6       = 4'd6;
  localparam logic [3:0] VAL_7       = 4'd7;
  localparam logic [3:0] VAL_8       = 4'd8;
  localparam logic [3:0] VAL_9       = 4'd9;
  localparam logic [3:0] VAL_SKIP    = 4'd10;
  localparam logic [3:0] VAL_REVERSE = 4'd11;
  localparam logic [3:0] VAL_DRAW2   = 4'd12;
  localparam logic [3:0] VAL_WILD    = 4'd13;
  localparam logic [3:0] VAL_WILD4   = 4'd14;

  localparam int DECK_SIZE = 108;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DEAL  = 3'd2,
    S_FLIP  = 3'd3,
    S_READY = 3'd4,
    S_EMPTY = 3'd5
  } dealer_state_e;

  function automatic card_t mk_card(input color_e color, input logic [3:0] value);
    return {color, value};
  endfunction

endpackage

// File: rtl/card_dealer_card_out_reg.sv
// rtl/card_dealer_card_out_reg.sv - valid/ready holding register for the outgoing card
module card_out_reg
  import uno_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       load,
  input  card_t      load_card,
  input  logic [1:0] load_player,
  input  logic       ready,
  output logic       valid,
  output card_t      card,
  output logic [1:0] player
);

  // Flush beats a new load; a new load may replace a card being accepted the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      card   <= '0;
      player <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      card   <= load_card;
      player <= load_player;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals opening hands, flips discard, serves draws; option CARD_DEALER_RESHUFFLE_REQ_EN
module card_dealer
  import uno_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int HAND_SIZE   = 7
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_deck_load,
  input  card_t      i_deck [DECK_SIZE-1:0],
  input  logic       i_draw_req,
  input  logic [1:0] i_draw_player,
  input  logic       i_play_valid,
  input  card_t      i_play_card,
  input  logic       i_card_ready,
  output logic       o_card_valid,
  output card_t      o_card,
  output logic [1:0] o_card_player,
  output card_t      o_top_card,
  output logic       o_top_valid,
  output logic [6:0] o_remaining,
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
  output logic       o_reshuffle_req,
`endif
  output logic       o_dealing,
  output logic       o_empty
);

  localparam int         DEAL_TOTAL = NUM_PLAYERS * HAND_SIZE;
  localparam logic [6:0] DECK_END   = 7'(DECK_SIZE);
  localparam logic [6:0] DEAL_LAST  = 7'(DEAL_TOTAL - 1);
  localparam logic [1:0] PLR_LAST   = 2'(NUM_PLAYERS - 1);

  dealer_state_e state;
  card_t         pile [DECK_SIZE-1:0];
  logic [6:0]    ptr;
  logic [6:0]    deal_cnt;
  logic [1:0]    deal_plr;

  logic [6:0]    ptr_idx;
  logic [6:0]    nxt_idx;
  logic [1:0]    nxt_plr;
  logic          can_take;
  logic          flush;
  logic          out_load;
  card_t         out_card;
  logic [1:0]    out_player;

`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
  logic          reload_only;
`endif

  // Clamp indices so a pointer parked at DECK_END never addresses outside the pile.
  always_comb begin
    ptr_idx  = (ptr < DECK_END) ? ptr : '0;
    nxt_idx  = ((ptr + 7'd1) < DECK_END) ? (ptr + 7'd1) : '0;
    nxt_plr  = (deal_plr == PLR_LAST) ? 2'd0 : deal_plr + 2'd1;
    can_take = !o_card_valid || i_card_ready;
    flush    = i_deck_load && (state != S_LOAD);
  end

  // Decide what, if anything, enters the output register this cycle.
  always_comb begin
    out_load   = 1'b0;
    out_card   = pile[ptr_idx];
    out_player = deal_plr;
    case (state)
      S_DEAL: begin
        if (!o_card_valid) begin
          out_load = 1'b1;
        end else if (i_card_ready && (deal_cnt != DEAL_LAST)) begin
          out_load   = 1'b1;
          out_card   = pile[nxt_idx];
          out_player = nxt_plr;
        end
      end
      S_READY: begin
        if (i_draw_req && (ptr != DECK_END) && can_take) begin
          out_load   = 1'b1;
          out_player = i_draw_player;
        end
      end
      default: ;
    endcase
  end

  card_out_reg u_out (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .load        (out_load),
    .load_card   (out_card),
    .load_player (out_player),
    .ready       (i_card_ready),
    .valid       (o_card_valid),
    .card        (o_card),
    .player      (o_card_player)
  );

  // Dealer sequencing: load, deal, flip, serve draws, and discard-pile tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      ptr         <= '0;
      deal_cnt    <= '0;
      deal_plr    <= '0;
      o_top_card  <= '0;
      o_top_valid <= 1'b0;
      o_empty     <= 1'b0;
      for (int i = 0; i < DECK_SIZE; i++) pile[i] <= '0;
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
      reload_only     <= 1'b0;
      o_reshuffle_req <= 1'b0;
`endif
    end else begin
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
      o_reshuffle_req <= 1'b0;
`endif
      if (flush) begin
        state   <= S_LOAD;
        o_empty <= 1'b0;
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
        reload_only <= (state == S_EMPTY);
        if (state != S_EMPTY) o_top_valid <= 1'b0;
`else
        o_top_valid <= 1'b0;
`endif
      end else begin
        case (state)
          S_LOAD: begin
            pile     <= i_deck;
            ptr      <= '0;
            deal_cnt <= '0;
            deal_plr <= '0;
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
            reload_only <= 1'b0;
            state       <= reload_only ? S_READY : S_DEAL;
`else
            state <= S_DEAL;
`endif
          end
          S_DEAL: begin
            if (o_card_valid && i_card_ready) begin
              ptr      <= ptr + 7'd1;
              deal_cnt <= deal_cnt + 7'd1;
              deal_plr <= nxt_plr;
              if (deal_cnt == DEAL_LAST) state <= S_FLIP;
            end
          end
          S_FLIP: begin
            o_top_card  <= pile[ptr_idx];
            o_top_valid <= 1'b1;
            ptr         <= ptr + 7'd1;
            if ((ptr + 7'd1) == DECK_END) begin
              state   <= S_EMPTY;
              o_empty <= 1'b1;
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
              o_reshuffle_req <= 1'b1;
`endif
            end else begin
              state <= S_READY;
            end
          end
          S_READY: begin
            if (out_load) ptr <= ptr + 7'd1;
            if (i_play_valid) o_top_card <= i_play_card;
            if ((ptr == DECK_END) && can_take) begin
              state   <= S_EMPTY;
              o_empty <= 1'b1;
`ifdef CARD_DEALER_RESHUFFLE_REQ_EN
              o_reshuffle_req <= 1'b1;
`endif
            end
          end
          S_EMPTY: begin
            if (i_play_valid) o_top_card <= i_play_card;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_remaining = (state == S_IDLE) ? 7'd0 : (DECK_END - ptr);
  assign o_dealing   = (state == S_LOAD) || (state == S_DEAL) || (state == S_FLIP);

endmodule
